spi_ram_arbiter: RTL

- Shares one single-port RAM (1-cycle read latency) between two requesters: the SPI slave command stream and a local host port.
- Decodes 10-bit SPI words into RAM accesses and returns read data to the SPI slave's tx_data/tx_valid for MISO shifting.
- Sits between the SPI slave and the RAM macro.
- Arbitration is round-robin, with one access in flight at a time.

---
 rtl/spi_ram_arbiter_pkg.sv | 21 ++
 rtl/spi_ram_arbiter_cmd_decoder.sv | 68 ++++++
 rtl/spi_ram_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI/host RAM arbiter: SPI opcodes, FSM states,
// and requester IDs.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    SPI  = 1'b0,
    HOST = 1'b1
  } req_id_e;

endpackage

// File: rtl/spi_ram_arbiter_cmd_decoder.sv
// Decodes 10-bit SPI words into address updates and a single-entry pending
// RAM op. Overrun is sticky until reset.
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 pend_take,
  output logic                 pend_vld,
  output logic                 pend_we,
  output logic [ADDR_SIZE-1:0] pend_addr,
  output logic [DATA_W-1:0]    pend_wdata,
  output logic                 overrun
);

  logic [1:0]           op;
  logic [7:0]           pl;
  logic                 is_acc;
  logic                 slot_free;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 pend_vld_q, pend_we_q, overrun_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [DATA_W-1:0]    pend_wdata_q;

  assign op        = rx_data[9:8];
  assign pl        = rx_data[7:0];
  assign is_acc    = rx_valid && (op == OP_WR_DATA || op == OP_RD_DATA);
  // A grant in this cycle empties the slot, so a new op can land at once.
  assign slot_free = !pend_vld_q || pend_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_vld_q   <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (pend_take) pend_vld_q <= 1'b0;
      if (rx_valid && op == OP_WR_ADDR) wr_addr_q <= ADDR_SIZE'(pl);
      if (rx_valid && op == OP_RD_ADDR) rd_addr_q <= ADDR_SIZE'(pl);
      if (is_acc) begin
        if (slot_free) begin
          pend_vld_q   <= 1'b1;
          pend_we_q    <= (op == OP_WR_DATA);
          pend_addr_q  <= (op == OP_WR_DATA) ? wr_addr_q : rd_addr_q;
          pend_wdata_q <= DATA_W'(pl);
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign pend_vld   = pend_vld_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_wdata = pend_wdata_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the SPI command
// stream and a host port; one access in flight, SPI read data held on tx.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8,
  parameter int TX_HOLD   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 spi_overrun,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  localparam int HW = $clog2(TX_HOLD + 1);

  logic                 pend_vld, pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [DATA_W-1:0]    pend_wdata;
  logic                 gnt_spi, gnt_host;

  arb_state_e           state_q;
  req_id_e              last_q, owner_q;
  logic                 ram_en_q, ram_we_q;
  logic [ADDR_SIZE-1:0] ram_addr_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic                 host_rvalid_q;
  logic [DATA_W-1:0]    host_rdata_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic [HW-1:0]        hold_q;

  spi_cmd_decoder #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (DATA_W)
  ) u_dec (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pend_take  (gnt_spi),
    .pend_vld   (pend_vld),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .overrun    (spi_overrun)
  );

  // On a tie, the requester that did not win last time gets the RAM.
  always_comb begin
    gnt_spi  = 1'b0;
    gnt_host = 1'b0;
    if (!rst && state_q == ARB) begin
      if (pend_vld && host_req) begin
        if (last_q == HOST) gnt_spi  = 1'b1;
        else                gnt_host = 1'b1;
      end else if (pend_vld) begin
        gnt_spi = 1'b1;
      end else if (host_req) begin
        gnt_host = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      last_q        <= HOST;
      owner_q       <= SPI;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      hold_q        <= '0;
    end else begin
      host_rvalid_q <= 1'b0;
      if (tx_valid_q) begin
        if (hold_q == HW'(1)) begin
          tx_valid_q <= 1'b0;
          hold_q     <= '0;
        end else begin
          hold_q <= hold_q - HW'(1);
        end
      end
      case (state_q)
        ARB: begin
          if (gnt_spi) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= pend_we;
            ram_addr_q  <= pend_addr;
            ram_wdata_q <= pend_we ? pend_wdata : '0;
            owner_q     <= SPI;
            last_q      <= SPI;
            state_q     <= ACCESS;
          end else if (gnt_host) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= host_we;
            ram_addr_q  <= host_addr;
            ram_wdata_q <= host_we ? host_wdata : '0;
            owner_q     <= HOST;
            last_q      <= HOST;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          state_q     <= ram_we_q ? ARB : RD_WAIT;
        end
        RD_WAIT: begin
          // A fresh SPI result overrides the running hold countdown.
          if (owner_q == HOST) begin
            host_rdata_q  <= ram_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            tx_data_q  <= ram_rdata[7:0];
            tx_valid_q <= 1'b1;
            hold_q     <= HW'(TX_HOLD);
          end
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign host_gnt    = gnt_host;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule
